// File: rtl/ifetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_defines (package)
//  Description : Shared CPU constants, fetch FSM encoding and the fetch
//                buffer entry layout used by the instruction fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_defines;

    localparam int XLEN = 32;

    // Canonical no-op: addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    // Fetch bus tracking states
    typedef enum logic [1:0] {
        FETCH_IDLE   = 2'd0,  // nothing outstanding on the bus
        FETCH_WAIT_R = 2'd1,  // granted, response will be kept
        FETCH_DRAIN  = 2'd2   // granted, response will be thrown away
    } fetch_state_e;

    // One buffered fetch: where it came from and what was read
    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/ifetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_fifo
//  Description : Small synchronous FIFO holding {address, instruction} pairs
//                between the fetch bus and decode. Clear wins over push.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifetch_fifo
    import cpu_defines::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = $bits(fetch_entry_t),
    parameter int CNT_W = $clog2(DEPTH + 1),
    parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,       // synchronous, active-low
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty
);

    localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_do_pop;
    logic             w_do_push;
    logic [PTR_W-1:0] w_rd_ptr_inc;
    logic [PTR_W-1:0] w_wr_ptr_inc;

    // Qualify requests: never pop empty, never overfill, clear blocks writes
    always_comb begin
        w_do_pop     = i_pop & (r_count != '0);
        w_do_push    = i_push & ~i_clear & ((r_count != c_full_cnt) | w_do_pop);
        w_rd_ptr_inc = (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
        w_wr_ptr_inc = (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            if (w_do_push) begin
                r_wr_ptr <= w_wr_ptr_inc;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_unit
//  Description : Instruction fetch stage. Issues the PC on a req/gnt/rvalid
//                bus with at most one request in flight, buffers responses
//                toward decode, holds the PC stage and flushes on jumps.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifetch_unit
    import cpu_defines::fetch_state_e;
    import cpu_defines::fetch_entry_t;
    import cpu_defines::FETCH_IDLE;
    import cpu_defines::FETCH_WAIT_R;
    import cpu_defines::FETCH_DRAIN;
#(
    parameter int                           DEPTH    = 2,
    parameter logic [cpu_defines::XLEN-1:0] NOP_INST = cpu_defines::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,            // synchronous, active-low
    input  logic [31:0] pc_i,
    input  logic        jump_en_i,
    output logic        pc_hold_o,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o,
    input  logic        inst_ready_i
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = CNT_W + 2;

    fetch_state_e r_state;
    fetch_state_e w_state_next;
    logic [31:0]  r_resp_addr;
    logic [31:0]  r_last_addr;

    logic             w_busy;
    logic             w_outst;
    logic             w_keep;
    logic             w_pop;
    logic             w_push;
    logic             w_space;
    logic             w_req;
    logic             w_grant;
    logic [SUM_W-1:0] w_need;
    logic [SUM_W-1:0] w_limit;

    fetch_entry_t     w_wentry;
    fetch_entry_t     w_head;
    logic [CNT_W-1:0] w_count;
    logic             w_empty;

    // Bus bookkeeping and the request/hold decision
    always_comb begin
        w_busy  = (r_state == FETCH_WAIT_R) | (r_state == FETCH_DRAIN);
        w_outst = w_busy & ~ibus_rvalid_i;
        w_keep  = (r_state == FETCH_WAIT_R) & ibus_rvalid_i;
        w_pop   = ~w_empty & inst_ready_i;
        w_push  = w_keep & ~jump_en_i;
        // Room check rearranged as fill < DEPTH + pop to stay unsigned
        w_need  = SUM_W'(w_count) + SUM_W'(w_outst) + SUM_W'(w_keep);
        w_limit = SUM_W'(DEPTH) + SUM_W'(w_pop);
        w_space = (w_need < w_limit);
        // A new request may overlap the cycle the previous response lands
        w_req   = rst & w_space & ~jump_en_i &
                  ((r_state == FETCH_IDLE) | (w_busy & ibus_rvalid_i));
        w_grant = w_req & ibus_gnt_i;
    end

    // Next-state logic for the outstanding-request tracker
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FETCH_IDLE: begin
                if (w_grant) begin
                    w_state_next = jump_en_i ? FETCH_DRAIN : FETCH_WAIT_R;
                end
            end
            FETCH_WAIT_R: begin
                if (ibus_rvalid_i) begin
                    if (w_grant) begin
                        w_state_next = jump_en_i ? FETCH_DRAIN : FETCH_WAIT_R;
                    end else begin
                        w_state_next = FETCH_IDLE;
                    end
                end else if (jump_en_i) begin
                    w_state_next = FETCH_DRAIN;
                end
            end
            FETCH_DRAIN: begin
                if (ibus_rvalid_i) begin
                    if (w_grant) begin
                        w_state_next = jump_en_i ? FETCH_DRAIN : FETCH_WAIT_R;
                    end else begin
                        w_state_next = FETCH_IDLE;
                    end
                end
            end
            default: w_state_next = FETCH_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= FETCH_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Remember which address the in-flight response belongs to
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_resp_addr <= '0;
        end else if (w_grant) begin
            r_resp_addr <= pc_i;
        end
    end

    // Registered copy of the presented address so it holds while empty
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_addr <= '0;
        end else begin
            r_last_addr <= inst_addr_o;
        end
    end

    assign w_wentry.addr = r_resp_addr;
    assign w_wentry.inst = ibus_rdata_i;

    ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (jump_en_i),
        .i_wdata (w_wentry),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    assign ibus_req_o   = w_req;
    assign ibus_addr_o  = pc_i;
    assign pc_hold_o    = ~w_grant;

    // Decode-side outputs come only from registered state
    assign inst_valid_o = ~w_empty;
    assign inst_o       = w_empty ? NOP_INST    : w_head.inst;
    assign inst_addr_o  = w_empty ? r_last_addr : w_head.addr;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifetch_unit
//  Description : Self-checking bench for ifetch_unit. A PC-stage model and a
//                bus responder drive the DUT; a scoreboard queue of granted
//                addresses is checked against what decode receives.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_unit;
    import cpu_defines::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        jump_en_i;
    logic        pc_hold_o;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;
    logic        inst_ready_i;

    always #5 clk = ~clk;

    ifetch_unit #(
        .DEPTH    (DEPTH),
        .NOP_INST (NOP_INST)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_i          (pc_i),
        .jump_en_i     (jump_en_i),
        .pc_hold_o     (pc_hold_o),
        .ibus_req_o    (ibus_req_o),
        .ibus_addr_o   (ibus_addr_o),
        .ibus_gnt_i    (ibus_gnt_i),
        .ibus_rvalid_i (ibus_rvalid_i),
        .ibus_rdata_i  (ibus_rdata_i),
        .inst_o        (inst_o),
        .inst_addr_o   (inst_addr_o),
        .inst_valid_o  (inst_valid_o),
        .inst_ready_i  (inst_ready_i)
    );

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];
    int          pop_count = 0;
    logic [31:0] last_pop_addr = '0;
    logic [31:0] m_addr;

    // Bus responder and PC-stage model state
    bit          pending = 0;
    int          delay = 0;
    logic [31:0] p_addr = '0;
    logic [31:0] pc_model = '0;
    logic        g_last = 1'b0;
    logic        s_req = 1'b0;
    logic        s_hold = 1'b0;
    logic [31:0] s_addr = '0;

    // Memory contents as seen by the bus: a fixed scramble of the address
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000 ^ {a[7:0], 24'h00_0001};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: apply inputs after the edge, sample settled outputs,
    // advance the bus and PC models, then move to just past the next edge.
    task automatic step(input logic rst_v, input logic jmp, input logic [31:0] tgt,
                        input logic rdy, input int gpct, input int dmin, input int dmax);
        bit rv;
        rv            = pending && (delay == 0);
        rst           = rst_v;
        jump_en_i     = jmp;
        inst_ready_i  = rdy;
        pc_i          = pc_model;
        ibus_rvalid_i = rv;
        ibus_rdata_i  = rv ? word_of(p_addr) : $urandom;
        ibus_gnt_i    = (int'($urandom % 100) < gpct) && (!pending || rv);
        #2;
        s_req  = ibus_req_o;
        s_hold = pc_hold_o;
        s_addr = ibus_addr_o;
        g_last = ibus_req_o && ibus_gnt_i;
        check("pc_hold", 32'(pc_hold_o), 32'(!g_last));
        if (ibus_req_o) check("ibus_addr", ibus_addr_o, pc_i);
        if (!rst_v) check("req_in_reset", 32'(ibus_req_o), 32'd0);
        if (rv) pending = 0;
        else if (pending) delay--;
        if (g_last) begin
            pending = 1;
            p_addr  = pc_model;
            delay   = int'($urandom_range(dmax, dmin));
        end
        if (!rst_v) pc_model = '0;
        else if (jmp) pc_model = tgt;
        else if (g_last) pc_model = pc_model + 32'd4;
        @(posedge clk);
        #1;
    endtask

    // Run until decode takes its next instruction and check where it came from
    task automatic expect_first_pop(input string name, input logic [31:0] want);
        int start;
        start = pop_count;
        for (int i = 0; i < 20 && pop_count == start; i++) step(1, 0, 0, 1, 100, 0, 0);
        if (pop_count == start) begin
            tests++;
            fails++;
            $display("FAIL %s: no instruction within 20 cycles, expected addr %h", name, want);
        end else begin
            check(name, last_pop_addr, want);
        end
    endtask

    // Scoreboard: pop on consumption, flush on jump/reset, push on grant
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
        end else begin
            if (!inst_valid_o) check("nop_when_empty", inst_o, NOP_INST);
            if (inst_valid_o && inst_ready_i) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_inst: got addr %h, expected no instruction", inst_addr_o);
                end else begin
                    m_addr = exp_q.pop_front();
                    check("inst_addr", inst_addr_o, m_addr);
                    check("inst_data", inst_o, word_of(m_addr));
                    pop_count++;
                    last_pop_addr = inst_addr_o;
                end
            end
            if (jump_en_i) exp_q.delete();
            if (ibus_req_o && ibus_gnt_i) begin
                exp_q.push_back(pc_i);
                if (exp_q.size() > DEPTH) begin
                    tests++;
                    fails++;
                    $display("FAIL capacity: got %0d buffered+inflight, expected at most %0d",
                             exp_q.size(), DEPTH);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; jump_en_i = 1'b0; inst_ready_i = 1'b0; pc_i = '0;
        ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0; ibus_rdata_i = '0;
        @(posedge clk);
        #1;

        // Reset state
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        check("rst_valid", 32'(inst_valid_o), 32'd0);
        check("rst_inst", inst_o, NOP_INST);
        check("rst_addr", inst_addr_o, 32'd0);
        check("rst_req", 32'(ibus_req_o), 32'd0);
        check("rst_hold", 32'(pc_hold_o), 32'd1);

        // Zero-wait streaming: 0,4,8,... one per cycle from cycle 2
        for (int k = 0; k < 8; k++) begin
            step(1, 0, 0, 1, 100, 0, 0);
            check("zw_grant", 32'(g_last), 32'd1);
            check("zw_valid", 32'(inst_valid_o), 32'(k + 1 >= 2));
            if (k + 1 >= 2) check("zw_addr", inst_addr_o, 32'(4 * (k - 1)));
        end

        // Decode stall: buffer fills to DEPTH, fetching stops
        for (int k = 0; k < 5; k++) step(1, 0, 0, 0, 100, 0, 0);
        check("stall_req", 32'(s_req), 32'd0);
        check("stall_hold", 32'(s_hold), 32'd1);
        check("stall_fill", 32'(exp_q.size()), 32'(DEPTH));
        check("stall_valid", 32'(inst_valid_o), 32'd1);
        for (int k = 0; k < 4; k++) step(1, 0, 0, 1, 100, 0, 0);

        // Grant withheld with pc at 0x40
        step(1, 1, 32'h40, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0, 1, 0, 0, 0);
            check("nognt_req", 32'(s_req), 32'd1);
            check("nognt_addr", s_addr, 32'h40);
            check("nognt_hold", 32'(s_hold), 32'd1);
        end
        begin
            int start;
            start = pop_count;
            step(1, 0, 0, 1, 100, 0, 0);
            for (int k = 0; k < 4; k++) step(1, 0, 0, 1, 0, 0, 0);
            check("nognt_count", 32'(pop_count - start), 32'd1);
            check("nognt_popaddr", last_pop_addr, 32'h40);
        end

        // Jump while a slow response is outstanding
        step(1, 0, 0, 1, 100, 2, 2);
        step(1, 1, 32'h100, 1, 0, 0, 0);
        expect_first_pop("jump_waitr", 32'h100);

        // Jump in the same cycle as rvalid
        step(1, 0, 0, 1, 100, 0, 0);
        step(1, 1, 32'h200, 1, 0, 0, 0);
        expect_first_pop("jump_rvalid", 32'h200);

        // Jump with a full buffer while decode pops
        for (int k = 0; k < 5; k++) step(1, 0, 0, 0, 100, 0, 0);
        step(1, 1, 32'h300, 1, 0, 0, 0);
        check("jump_full_empty", 32'(inst_valid_o), 32'd0);
        expect_first_pop("jump_full", 32'h300);

        // Reset mid-fetch; the late response lands right after release
        step(1, 0, 0, 1, 100, 1, 1);
        step(0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0, 1, 0, 0, 0);
            check("rst_late_valid", 32'(inst_valid_o), 32'd0);
        end
        step(1, 0, 0, 1, 100, 0, 0);
        check("rst_refetch_grant", 32'(g_last), 32'd1);
        check("rst_refetch_addr", s_addr, 32'd0);

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            step(($urandom % 200) != 0, ($urandom % 20) == 0, ($urandom % 256) * 4,
                 ($urandom % 4) != 0, 70, 0, 3);
        end

        // Drain: everything granted must reach decode
        for (int k = 0; k < 15; k++) step(1, 0, 0, 1, 0, 0, 3);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
